// File: rtl/gst_lmc_pkg.sv
// gst_lmc_pkg -- shared constants for the LMC1992 microwire receiver.
// Holds the function codes, the register address, the per-channel maxima
// and the power-on values of every setting, plus the mix-code check.
package gst_lmc_pkg;

  // Function field (frame[8:6])
  typedef enum logic [2:0] {
    FN_MIX    = 3'b000,
    FN_BASS   = 3'b001,
    FN_TREBLE = 3'b010,
    FN_MASTER = 3'b011,
    FN_RIGHT  = 3'b100,
    FN_LEFT   = 3'b101
  } lmc_fn_e;

  localparam logic [1:0] LMC_ADDR   = 2'b10;
  localparam logic [4:0] FRAME_BITS = 5'd11;

  // Per-channel maxima, already at channel width
  localparam logic [3:0] MAX_TONE   = 4'd12;
  localparam logic [4:0] MAX_LR     = 5'd20;
  localparam logic [5:0] MAX_MASTER = 6'd40;

  // Reset values
  localparam logic [5:0] RST_MASTER = 6'd40;
  localparam logic [4:0] RST_LR     = 5'd20;
  localparam logic [3:0] RST_TONE   = 4'd6;
  localparam logic [1:0] RST_MIX    = 2'b01;

  // True for function codes the chip accepts; mix code 11 is reserved.
  function automatic logic lmc_fn_valid(input logic [2:0] fn, input logic [1:0] mix_bits);
    case (fn)
      FN_MIX:                                  return (mix_bits != 2'b11);
      FN_BASS, FN_TREBLE, FN_MASTER,
      FN_RIGHT, FN_LEFT:                       return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lmc_ramp.sv
// lmc_ramp -- one ramped LMC1992 channel.
// Holds the applied value and its target; on each tick the applied value
// moves one step toward the target. A target write in the same cycle as a
// tick only affects later ticks, because the step compares against the
// target register as it was before the edge.
// Ports:
//   i_clk32   system clock
//   i_res     asynchronous active-high reset (loads RST_VAL)
//   i_tick    ramp step strobe
//   i_wr_en   load a new target
//   i_wr_val  new target (already clamped)
//   o_cur     currently applied value
//   o_differs applied value not yet equal to target
module lmc_ramp #(
  parameter int         W       = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk32,
  input  logic         i_res,
  input  logic         i_tick,
  input  logic         i_wr_en,
  input  logic [W-1:0] i_wr_val,
  output logic [W-1:0] o_cur,
  output logic         o_differs
);

  logic [W-1:0] r_cur;
  logic [W-1:0] r_tgt;

  always_ff @(posedge i_clk32 or posedge i_res) begin
    if (i_res) begin
      r_cur <= RST_VAL;
      r_tgt <= RST_VAL;
    end else begin
      if (i_wr_en) begin
        r_tgt <= i_wr_val;
      end
      if (i_tick) begin
        if (r_cur < r_tgt) begin
          r_cur <= r_cur + 1'b1;
        end else if (r_cur > r_tgt) begin
          r_cur <= r_cur - 1'b1;
        end
      end
    end
  end

  assign o_cur     = r_cur;
  assign o_differs = (r_cur != r_tgt);

endmodule

// File: rtl/mw_lmc_rx.sv
// mw_lmc_rx -- microwire receiver for LMC1992-style tone/volume commands.
// Deserialises 11-bit frames (MSB first), validates and clamps them, and
// drives the applied settings; volume and tone channels ramp one step per
// RAMP_DIV clocks, mix changes immediately.
// Ports:
//   clk32        system clock
//   res          asynchronous active-high reset
//   mw_clk       microwire bit clock (synchronous to clk32)
//   mw_data      microwire data, sampled on mw_clk rise
//   mw_done      frame close, evaluated on its rise
//   master_vol, left_vol, right_vol, bass, treble, mix  applied settings
//   cmd_ok / cmd_err  one-cycle result pulse per non-empty frame
//   ramp_active  some ramped channel has not reached its target
module mw_lmc_rx
  import gst_lmc_pkg::*;
#(
  parameter int RAMP_DIV = 32000
) (
  input  logic       clk32,
  input  logic       res,
  input  logic       mw_clk,
  input  logic       mw_data,
  input  logic       mw_done,
  output logic [5:0] master_vol,
  output logic [4:0] left_vol,
  output logic [4:0] right_vol,
  output logic [3:0] bass,
  output logic [3:0] treble,
  output logic [1:0] mix,
  output logic       cmd_ok,
  output logic       cmd_err,
  output logic       ramp_active
);

  localparam int TW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(RAMP_DIV - 1);

  logic          r_mw_clk_d;
  logic          r_mw_done_d;
  logic [10:0]   r_shift;
  logic [4:0]    r_bit_cnt;
  logic          r_cmd_ok;
  logic          r_cmd_err;
  logic          r_ramp_active;
  logic [1:0]    r_mix;
  logic [TW-1:0] r_tick_cnt;

  logic          w_clk_rise;
  logic          w_done_rise;
  logic [10:0]   w_shift_next;
  logic [4:0]    w_cnt_inc;
  logic [10:0]   w_frame;
  logic [4:0]    w_count;
  logic [1:0]    w_addr;
  logic [2:0]    w_fn;
  logic [5:0]    w_data;
  logic          w_accept;
  logic          w_reject;
  logic          w_tick;
  logic [4:0]    w_differs;

  logic          w_wr_mix, w_wr_bass, w_wr_treble, w_wr_master, w_wr_right, w_wr_left;
  logic [5:0]    w_master_val;
  logic [4:0]    w_lr_val;
  logic [3:0]    w_tone_val;

  assign w_clk_rise   = mw_clk & ~r_mw_clk_d;
  assign w_done_rise  = mw_done & ~r_mw_done_d;
  assign w_shift_next = {r_shift[9:0], mw_data};
  assign w_cnt_inc    = (r_bit_cnt == 5'd31) ? 5'd31 : r_bit_cnt + 5'd1;

  // A bit arriving in the closing cycle still belongs to the frame.
  assign w_frame = w_clk_rise ? w_shift_next : r_shift;
  assign w_count = w_clk_rise ? w_cnt_inc : r_bit_cnt;
  assign w_addr  = w_frame[10:9];
  assign w_fn    = w_frame[8:6];
  assign w_data  = w_frame[5:0];

  assign w_accept = w_done_rise && (w_count == FRAME_BITS) && (w_addr == LMC_ADDR)
                    && lmc_fn_valid(w_fn, w_data[1:0]);
  assign w_reject = w_done_rise && !w_accept && (w_count != 5'd0);

  assign w_wr_mix    = w_accept && (w_fn == FN_MIX);
  assign w_wr_bass   = w_accept && (w_fn == FN_BASS);
  assign w_wr_treble = w_accept && (w_fn == FN_TREBLE);
  assign w_wr_master = w_accept && (w_fn == FN_MASTER);
  assign w_wr_right  = w_accept && (w_fn == FN_RIGHT);
  assign w_wr_left   = w_accept && (w_fn == FN_LEFT);

  assign w_master_val = (w_data > MAX_MASTER)      ? MAX_MASTER : w_data;
  assign w_lr_val     = (w_data[4:0] > MAX_LR)     ? MAX_LR     : w_data[4:0];
  assign w_tone_val   = (w_data[3:0] > MAX_TONE)   ? MAX_TONE   : w_data[3:0];

  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge clk32 or posedge res) begin
    if (res) begin
      r_mw_clk_d    <= 1'b0;
      r_mw_done_d   <= 1'b0;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_cmd_ok      <= 1'b0;
      r_cmd_err     <= 1'b0;
      r_ramp_active <= 1'b0;
      r_mix         <= RST_MIX;
      r_tick_cnt    <= '0;
    end else begin
      r_mw_clk_d  <= mw_clk;
      r_mw_done_d <= mw_done;
      if (w_clk_rise) begin
        r_shift <= w_shift_next;
      end
      if (w_done_rise) begin
        r_bit_cnt <= '0;
      end else if (w_clk_rise) begin
        r_bit_cnt <= w_cnt_inc;
      end
      r_cmd_ok  <= w_accept;
      r_cmd_err <= w_reject;
      if (w_wr_mix) begin
        r_mix <= w_data[1:0];
      end
      r_tick_cnt    <= w_tick ? '0 : r_tick_cnt + 1'b1;
      r_ramp_active <= |w_differs;
    end
  end

  lmc_ramp #(.W(6), .RST_VAL(RST_MASTER)) u_master (
    .i_clk32(clk32), .i_res(res), .i_tick(w_tick), .i_wr_en(w_wr_master),
    .i_wr_val(w_master_val), .o_cur(master_vol), .o_differs(w_differs[0])
  );

  lmc_ramp #(.W(5), .RST_VAL(RST_LR)) u_left (
    .i_clk32(clk32), .i_res(res), .i_tick(w_tick), .i_wr_en(w_wr_left),
    .i_wr_val(w_lr_val), .o_cur(left_vol), .o_differs(w_differs[1])
  );

  lmc_ramp #(.W(5), .RST_VAL(RST_LR)) u_right (
    .i_clk32(clk32), .i_res(res), .i_tick(w_tick), .i_wr_en(w_wr_right),
    .i_wr_val(w_lr_val), .o_cur(right_vol), .o_differs(w_differs[2])
  );

  lmc_ramp #(.W(4), .RST_VAL(RST_TONE)) u_bass (
    .i_clk32(clk32), .i_res(res), .i_tick(w_tick), .i_wr_en(w_wr_bass),
    .i_wr_val(w_tone_val), .o_cur(bass), .o_differs(w_differs[3])
  );

  lmc_ramp #(.W(4), .RST_VAL(RST_TONE)) u_treble (
    .i_clk32(clk32), .i_res(res), .i_tick(w_tick), .i_wr_en(w_wr_treble),
    .i_wr_val(w_tone_val), .o_cur(treble), .o_differs(w_differs[4])
  );

  assign mix         = r_mix;
  assign cmd_ok      = r_cmd_ok;
  assign cmd_err     = r_cmd_err;
  assign ramp_active = r_ramp_active;

endmodule
